// File: rtl/tomasula_types.sv
// Shared types for the Tomasulo core: committed op encoding, the memory-commit
// FSM state, and helpers that classify memory ops.
package tomasula_types;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ALU,
        OP_BRANCH,
        OP_LW,
        OP_LH,
        OP_LHU,
        OP_LB,
        OP_LBU,
        OP_SW,
        OP_SH,
        OP_SB
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } mem_ctrl_state_t;

    function automatic logic is_load(input op_t op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_mem(input op_t op);
        return is_load(op) || is_store(op);
    endfunction

    // Byte accesses can never straddle a word, so they are never misaligned.
    function automatic logic is_misaligned(input op_t op, input logic [1:0] off);
        logic mis;
        unique case (op)
            OP_LW, OP_SW:         mis = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH: mis = off[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_commit_ctrl_load_align.sv
// Selects the addressed byte/halfword lane from a read word and sign- or
// zero-extends it to 32 bits according to the load op.
module load_align
    import tomasula_types::*;
(
    input  op_t         op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] ext_data
);

    logic [15:0] half;
    logic [7:0]  byte_lane;

    always_comb begin
        half = offset[1] ? rdata[31:16] : rdata[15:0];
        unique case (offset)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
        endcase
    end

    always_comb begin
        unique case (op)
            OP_LH:   ext_data = {{16{half[15]}}, half};
            OP_LHU:  ext_data = {16'h0000, half};
            OP_LB:   ext_data = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  ext_data = {24'h000000, byte_lane};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_commit_ctrl.sv
// Commit-time data-memory sequencer: latches the ROB-head load/store, issues
// one aligned byte-masked request, and returns extended load data with a done pulse.
module mem_commit_ctrl
    import tomasula_types::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit_valid,
    input  op_t                  commit_op,
    input  logic [31:0]          commit_addr,
    input  logic [31:0]          commit_wdata,
    input  logic                 data_mem_resp,
    input  logic [31:0]          data_mem_rdata,
    output logic                 data_read,
    output logic                 data_write,
    output logic [31:0]          data_mem_address,
    output logic [3:0]           data_mbe,
    output logic [31:0]          data_mem_wdata,
    output logic                 commit_done,
    output logic [31:0]          load_data,
    output logic                 misaligned,
    output logic [CNT_WIDTH-1:0] load_count,
    output logic [CNT_WIDTH-1:0] store_count
);

    mem_ctrl_state_t state_q, state_d;
    op_t             op_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     load_data_q;
    logic            mis_q;
    logic [31:0]     aligned_rdata;
    logic            accept;
    logic [1:0]      off;

    assign off    = addr_q[1:0];
    assign accept = (state_q == IDLE) && commit_valid && is_mem(commit_op);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)
                      state_d = is_misaligned(commit_op, commit_addr[1:0]) ? DONE : REQ;
            REQ:  if (data_mem_resp) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_read   = (state_q == REQ) && is_load(op_q);
        data_write  = (state_q == REQ) && is_store(op_q);
        commit_done = (state_q == DONE);
        misaligned  = (state_q == DONE) && mis_q;
    end

    load_align u_load_align (
        .op       (op_q),
        .offset   (off),
        .rdata    (data_mem_rdata),
        .ext_data (aligned_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_NOP;
            addr_q      <= '0;
            wdata_q     <= '0;
            mis_q       <= 1'b0;
            load_data_q <= '0;
        end else if (accept) begin
            op_q        <= commit_op;
            addr_q      <= commit_addr;
            wdata_q     <= commit_wdata;
            mis_q       <= is_misaligned(commit_op, commit_addr[1:0]);
            load_data_q <= '0;
        end else if ((state_q == REQ) && data_mem_resp && is_load(op_q)) begin
            load_data_q <= aligned_rdata;
        end
    end

    // Memory-facing outputs come only from latched state so they stay stable
    // while the ROB-side inputs are free to change.
    always_comb begin
        data_mem_address = {addr_q[31:2], 2'b00};
        data_mem_wdata   = wdata_q << {off, 3'b000};
        unique case (op_q)
            OP_SW, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: data_mbe = 4'b1111;
            OP_SH:   data_mbe = 4'b0011 << off;
            OP_SB:   data_mbe = 4'b0001 << off;
            default: data_mbe = 4'b0000;
        endcase
        load_data = load_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_count  <= '0;
            store_count <= '0;
        end else if ((state_q == DONE) && !mis_q) begin
            if (is_load(op_q)) load_count  <= load_count + CNT_WIDTH'(1);
            else               store_count <= store_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mem_commit_ctrl.sv
// Self-checking bench for mem_commit_ctrl: table-driven single ops with a
// scoreboard of expected results, plus reset, back-to-back and stray-resp sequences.
module tb_mem_commit_ctrl;
    import tomasula_types::*;

    logic        clk;
    logic        rst;
    logic        commit_valid;
    op_t         commit_op;
    logic [31:0] commit_addr;
    logic [31:0] commit_wdata;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_mem_address;
    logic [3:0]  data_mbe;
    logic [31:0] data_mem_wdata;
    logic        commit_done;
    logic [31:0] load_data;
    logic        misaligned;
    logic [31:0] load_count;
    logic [31:0] store_count;

    mem_commit_ctrl #(.CNT_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .commit_valid     (commit_valid),
        .commit_op        (commit_op),
        .commit_addr      (commit_addr),
        .commit_wdata     (commit_wdata),
        .data_mem_resp    (data_mem_resp),
        .data_mem_rdata   (data_mem_rdata),
        .data_read        (data_read),
        .data_write       (data_write),
        .data_mem_address (data_mem_address),
        .data_mbe         (data_mbe),
        .data_mem_wdata   (data_mem_wdata),
        .commit_done      (commit_done),
        .load_data        (load_data),
        .misaligned       (misaligned),
        .load_count       (load_count),
        .store_count      (store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        op_t         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_cycles;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mbe;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        bit          exp_mis;
        bit          is_st;
    } vec_t;

    vec_t vecs[13];
    vec_t sb[$];

    int n_checks  = 0;
    int n_pass    = 0;
    int exp_loads = 0;
    int exp_stores = 0;
    int exp_done  = 0;
    int done_seen = 0;

    always @(negedge clk) if (!rst && commit_done) done_seen++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int wc, input logic [31:0] ea,
                                input logic [3:0] em, input logic [31:0] ew, input logic [31:0] el,
                                input bit mis, input bit st);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.wait_cycles = wc;
        v.exp_addr = ea; v.exp_mbe = em; v.exp_wdata = ew; v.exp_load = el;
        v.exp_mis = mis; v.is_st = st;
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        vec_t e;
        @(negedge clk);
        commit_valid = 1'b1;
        commit_op    = v.op;
        commit_addr  = v.addr;
        commit_wdata = v.wdata;
        sb.push_back(v);
        @(negedge clk);
        if (v.exp_mis) begin
            check("mis_no_read", {31'b0, data_read}, 32'd0);
            check("mis_no_write", {31'b0, data_write}, 32'd0);
        end else begin
            for (int c = 0; c <= v.wait_cycles; c++) begin
                if (c > 0) @(negedge clk);
                check("req_read", {31'b0, data_read}, {31'b0, !v.is_st});
                check("req_write", {31'b0, data_write}, {31'b0, v.is_st});
                check("req_addr", data_mem_address, v.exp_addr);
                check("req_mbe", {28'b0, data_mbe}, {28'b0, v.exp_mbe});
                if (v.is_st) check("req_wdata", data_mem_wdata, v.exp_wdata);
                check("req_no_done", {31'b0, commit_done}, 32'd0);
                if (c == v.wait_cycles) begin
                    data_mem_resp  = 1'b1;
                    data_mem_rdata = v.rdata;
                end
            end
            @(negedge clk);
            data_mem_resp  = 1'b0;
            data_mem_rdata = $urandom;
            check("done_req_dropped", {30'b0, data_read, data_write}, 32'd0);
        end
        check("done_pulse", {31'b0, commit_done}, 32'd1);
        e = sb.pop_front();
        check("done_misaligned", {31'b0, misaligned}, {31'b0, e.exp_mis});
        if (!e.is_st && !e.exp_mis) check("load_data", load_data, e.exp_load);
        exp_done++;
        if (!e.exp_mis) begin
            if (e.is_st) exp_stores++;
            else         exp_loads++;
        end
        commit_valid = 1'b0;
        @(negedge clk);
        check("done_single", {31'b0, commit_done}, 32'd0);
        check("load_count", load_count, exp_loads);
        check("store_count", store_count, exp_stores);
    endtask

    initial begin
        rst            = 1'b1;
        commit_valid   = 1'b0;
        commit_op      = OP_NOP;
        commit_addr    = '0;
        commit_wdata   = '0;
        data_mem_resp  = 1'b0;
        data_mem_rdata = '0;

        vecs[0]  = mk(OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 3, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0);
        vecs[1]  = mk(OP_LB,  32'h103, 32'h0,        32'h80123456, 0, 32'h100, 4'b1111, 32'h0,        32'hFFFFFF80, 0, 0);
        vecs[2]  = mk(OP_LBU, 32'h103, 32'h0,        32'h80123456, 1, 32'h100, 4'b1111, 32'h0,        32'h00000080, 0, 0);
        vecs[3]  = mk(OP_LH,  32'h102, 32'h0,        32'h80017777, 0, 32'h100, 4'b1111, 32'h0,        32'hFFFF8001, 0, 0);
        vecs[4]  = mk(OP_LHU, 32'h102, 32'h0,        32'h80017777, 2, 32'h100, 4'b1111, 32'h0,        32'h00008001, 0, 0);
        vecs[5]  = mk(OP_LB,  32'h101, 32'h0,        32'h1234F67F, 0, 32'h100, 4'b1111, 32'h0,        32'hFFFFFFF6, 0, 0);
        vecs[6]  = mk(OP_SH,  32'h202, 32'h1234ABCD, 32'h0,        2, 32'h200, 4'b1100, 32'hABCD0000, 32'h0,        0, 1);
        vecs[7]  = mk(OP_SB,  32'h201, 32'h000000A5, 32'h0,        0, 32'h200, 4'b0010, 32'h0000A500, 32'h0,        0, 1);
        vecs[8]  = mk(OP_SW,  32'h300, 32'hCAFEF00D, 32'h0,        1, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 1);
        vecs[9]  = mk(OP_SW,  32'h301, 32'h11111111, 32'h0,        0, 32'h300, 4'b1111, 32'h0,        32'h0,        1, 1);
        vecs[10] = mk(OP_LH,  32'h101, 32'h0,        32'h0,        0, 32'h100, 4'b1111, 32'h0,        32'h0,        1, 0);
        vecs[11] = mk(OP_LW,  32'h102, 32'h0,        32'h0,        0, 32'h100, 4'b1111, 32'h0,        32'h0,        1, 0);
        vecs[12] = mk(OP_LHU, 32'h103, 32'h0,        32'h0,        0, 32'h100, 4'b1111, 32'h0,        32'h0,        1, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_read", {31'b0, data_read}, 32'd0);
        check("rst_write", {31'b0, data_write}, 32'd0);
        check("rst_addr", data_mem_address, 32'd0);
        check("rst_mbe", {28'b0, data_mbe}, 32'd0);
        check("rst_wdata", data_mem_wdata, 32'd0);
        check("rst_done", {31'b0, commit_done}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_mis", {31'b0, misaligned}, 32'd0);
        check("rst_load_count", load_count, 32'd0);
        check("rst_store_count", store_count, 32'd0);

        for (int i = 0; i < 13; i++) run_op(vecs[i]);

        // A non-memory op at the head must not start anything.
        commit_valid = 1'b1;
        commit_op    = OP_ALU;
        commit_addr  = 32'h500;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nonmem_idle", {29'b0, data_read, data_write, commit_done}, 32'd0);
        end
        commit_valid = 1'b0;

        // Response while idle is ignored.
        data_mem_resp = 1'b1;
        @(negedge clk);
        data_mem_resp = 1'b0;
        @(negedge clk);
        check("stray_resp", {29'b0, data_read, data_write, commit_done}, 32'd0);

        // Reset during REQ abandons the request and clears the counters.
        commit_valid = 1'b1;
        commit_op    = OP_LW;
        commit_addr  = 32'h600;
        @(negedge clk);
        check("rstreq_read_up", {31'b0, data_read}, 32'd1);
        rst          = 1'b1;
        commit_valid = 1'b0;
        @(negedge clk);
        check("rstreq_read_drop", {31'b0, data_read}, 32'd0);
        check("rstreq_no_done", {31'b0, commit_done}, 32'd0);
        rst = 1'b0;
        exp_loads  = 0;
        exp_stores = 0;
        @(negedge clk);
        check("rstreq_no_done2", {31'b0, commit_done}, 32'd0);
        check("rstreq_load_count", load_count, 32'd0);
        run_op(vecs[0]);

        // Back-to-back SBs with commit_valid held through DONE.
        @(negedge clk);
        commit_valid = 1'b1;
        commit_op    = OP_SB;
        commit_addr  = 32'h400;
        commit_wdata = 32'h0000005A;
        sb.push_back(mk(OP_SB, 32'h400, 32'h5A, 32'h0, 0, 32'h400, 4'b0001, 32'h5A, 32'h0, 0, 1));
        @(negedge clk);
        check("b2b_wr1", {31'b0, data_write}, 32'd1);
        check("b2b_mbe1", {28'b0, data_mbe}, 32'h1);
        check("b2b_wdata1", data_mem_wdata, 32'h0000005A);
        data_mem_resp = 1'b1;
        @(negedge clk);
        data_mem_resp = 1'b0;
        check("b2b_done1", {31'b0, commit_done}, 32'd1);
        check("b2b_mis1", {31'b0, misaligned}, {31'b0, sb.pop_front().exp_mis});
        commit_addr  = 32'h403;
        commit_wdata = 32'h000000C3;
        sb.push_back(mk(OP_SB, 32'h403, 32'hC3, 32'h0, 0, 32'h400, 4'b1000, 32'hC3000000, 32'h0, 0, 1));
        @(negedge clk);
        check("b2b_idle_gap", {29'b0, data_read, data_write, commit_done}, 32'd0);
        @(negedge clk);
        check("b2b_wr2", {31'b0, data_write}, 32'd1);
        check("b2b_mbe2", {28'b0, data_mbe}, 32'h8);
        check("b2b_wdata2", data_mem_wdata, 32'hC3000000);
        data_mem_resp = 1'b1;
        @(negedge clk);
        data_mem_resp = 1'b0;
        commit_valid  = 1'b0;
        check("b2b_done2", {31'b0, commit_done}, 32'd1);
        check("b2b_mis2", {31'b0, misaligned}, {31'b0, sb.pop_front().exp_mis});
        exp_stores += 2;
        exp_done   += 2;
        @(negedge clk);
        check("b2b_no_done3", {31'b0, commit_done}, 32'd0);
        check("b2b_store_count", store_count, exp_stores);
        repeat (2) @(negedge clk);

        check("total_done_pulses", done_seen, exp_done);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_commit_ctrl.md
# mem_commit_ctrl

Sequences the single data-memory port for loads and stores leaving the ROB head. The ROB presents a committing memory op together with its address (from the CDB) and store data (from the regfile). This block latches the op and drives one aligned, byte-masked memory transaction, waiting as long as memory takes. It then returns sign- or zero-extended load data and a one-cycle done pulse so the ROB can write the regfile and advance its head.

## Interface
Parameters:
- CNT_WIDTH, 32, width of the load/store performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- commit_valid  in  1  ROB head is a load/store ready to access memory. Held high until commit_done.
- commit_op  in  tomasula_types::op_t  LW/LH/LHU/LB/LBU/SW/SH/SB.
- commit_addr  in  32  byte address.
- commit_wdata  in  32  store data, unshifted, bits [7:0] = LSB.
- data_mem_resp  in  1  memory completes the current request.
- data_mem_rdata  in  32  read word; valid with resp.
- data_read  out  1  load request.
- data_write  out  1  store request.
- data_mem_address  out  32  {addr[31:2], 2'b00}.
- data_mbe  out  4  byte enables.
- data_mem_wdata  out  32  store data shifted into byte lanes.
- commit_done  out  1  one-cycle pulse; the op has finished.
- load_data  out  32  extended load result; valid while commit_done is high.
- misaligned  out  1  valid with commit_done; the op was not issued to memory.
- load_count  out  CNT_WIDTH  loads completed.
- store_count  out  CNT_WIDTH  stores completed.

## Operation
- The FSM has three states: IDLE, REQ, DONE.
- **IDLE:**
  - If commit_valid is high, latch op, addr and wdata into registers.
  - If the access is aligned, go to REQ.
  - If it is misaligned, go to DONE with misaligned=1.
- **Misalignment rules:**
  - LW/SW: addr[1:0]≠0.
  - LH/LHU/SH: addr[0]=1.
  - Byte accesses are never misaligned.
- **REQ:**
  - Assert data_read for loads or data_write for stores, never both.
  - The asserted request is held with address, mbe and wdata stable until data_mem_resp.
  - On resp for a load, register the extended data. For any op, go to DONE.
- **DONE:**
  - commit_done=1 for exactly one cycle.
  - Increment the matching counter unless misaligned.
  - Go to IDLE. commit_valid is ignored while in DONE.
- **Byte enables (off = addr[1:0]):**
  - SW: 1111.
  - SH: 0011<<off.
  - SB: 0001<<off.
  - Loads: 1111.
- **Store data:** data_mem_wdata = wdata << (8·off).
- **Load extension:**
  - LW: the whole word.
  - LH: sign-extend rdata[8·off+:16].
  - LHU: zero-extend rdata[8·off+:16].
  - LB: sign-extend rdata[8·off+:8].
  - LBU: zero-extend rdata[8·off+:8].
- **Non-memory ops:** a non-memory commit_op presented in IDLE is ignored; the FSM stays in IDLE.
- **Counters:** wrap modulo 2^CNT_WIDTH.

## Timing
- **Reset:**
  - Resets state to IDLE.
  - All outputs read 0, counters included.
  - data_mem_address is 0.
  - Reset during REQ abandons the request in the same edge, with no commit_done.
- **Latency:**
  - commit_valid seen at edge N → request high in cycle N+1.
  - resp in cycle N+k (k≥1) → commit_done in cycle N+k+1.
  - Minimum 2 cycles from commit_valid to done.
  - Misaligned op: done at N+1, no request.
- **Output registering:** data_mem_address, data_mbe, data_mem_wdata and the request strobes are driven from the latched registers, not from the commit_* inputs.
- **Back-to-back commits:** a new commit_valid is accepted in the IDLE cycle after DONE, so at most one op per 3 cycles.
- **Resp outside REQ:** a data_mem_resp arriving while not in REQ is ignored.

## Structure
- op_t already lives in tomasula_types.
- Add to that package:
  - state enum mem_ctrl_state_t {IDLE, REQ, DONE};
  - functions is_load(op_t) and is_misaligned(op_t, logic[1:0]).
- Sub-module load_align (combinational): op, offset and rdata in, extended word out. It is shared with any future load-forwarding path.

## Test plan
- **LW aligned:** commit LW @0x100, resp after 3 wait cycles with rdata 0xDEADBEEF → data_read held for 4 cycles, address 0x100, mbe 1111, then load_data 0xDEADBEEF with a single commit_done; load_count=1.
- **LB/LBU lane select:** @0x103 with rdata 0x80xxxxxx → 0xFFFFFF80 for LB and 0x00000080 for LBU. LH @0x102 with rdata 0x8001xxxx → 0xFFFF8001.
- **SH @0x0202 with wdata 0x1234ABCD** → address 0x200, mbe 1100, wdata 0xABCD0000, data_write held until resp; store_count increments.
- **Misaligned:** SW @0x301 → no data_read or data_write ever. commit_done at N+1 with misaligned=1; counters unchanged.
- **Reset during REQ:** rst during REQ → data_read drops next cycle, no commit_done. A following LW completes normally.
- **Back-to-back:** commit_valid held through DONE for two back-to-back SBs → exactly two transactions and two done pulses, with an IDLE cycle between them.
